// File: rtl/alu_mul_seq.sv
// alu_mul_seq: multi-cycle shift-add multiplier producing the low 32 bits of an
// unsigned 32x32 product. Every add and shift of the accumulate/multiplier path
// is performed by the shared external combinational ALU, which this block drives
// while busy. Requester side uses start/ready on input and valid/out_ack on output.
module alu_mul_seq #(
  parameter int         MAX_ITER = 32,
  parameter logic [2:0] OP_ADD   = 3'b010,
  parameter logic [2:0] OP_SRL   = 3'b101
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        ready,
  output logic        valid,
  input  logic        out_ack,
  output logic [31:0] product,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_res,
  input  logic        alu_zero
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Iteration index of the final shift; reaching it forces completion even if
  // the multiplier has not yet drained to zero.
  localparam logic [5:0] LAST_ITER = 6'(MAX_ITER - 1);

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplr_q, mplr_d;
  logic [5:0]  cnt_q, cnt_d;

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= 32'd0;
      mcand_q <= 32'd0;
      mplr_q  <= 32'd0;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, datapath updates and all outputs (ALU defaults to 0/0/ADD so
  // alu_op is always a defined code).
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    valid   = 1'b0;
    product = 32'd0;
    alu_a   = 32'd0;
    alu_b   = 32'd0;
    alu_op  = OP_ADD;

    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          acc_d   = 32'd0;
          mcand_d = a_in;
          mplr_d  = b_in;
          cnt_d   = 6'd0;
          state_d = S_ADD;
        end
      end

      S_ADD: begin
        alu_a  = acc_q;
        alu_b  = mcand_q;
        alu_op = OP_ADD;
        // Only accumulate the shifted multiplicand when the current multiplier
        // bit is set; the ALU sum wraps naturally modulo 2^32.
        if (mplr_q[0]) begin
          acc_d = alu_res;
        end
        state_d = S_SHIFT;
      end

      S_SHIFT: begin
        alu_a   = 32'd0;
        alu_b   = mplr_q;
        alu_op  = OP_SRL;
        mplr_d  = alu_res;
        // Multiplicand shift is done locally; the ALU is busy with the multiplier.
        mcand_d = mcand_q << 1;
        cnt_d   = cnt_q + 6'd1;
        // A drained multiplier means no further bits can contribute.
        if (alu_zero || (cnt_q == LAST_ITER)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ADD;
        end
      end

      S_DONE: begin
        valid   = 1'b1;
        product = acc_q;
        if (out_ack) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed and random checks of alu_mul_seq against a plain
// arithmetic reference (64-bit multiply, highest-set-bit latency rule), with a
// behavioural model of the shared ALU attached to the DUT.
module tb_alu_mul_seq;

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b101;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        ready;
  logic        valid;
  logic        out_ack;
  logic [31:0] product;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_res;
  logic        alu_zero;

  int checks = 0;
  int errors = 0;

  alu_mul_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .ready    (ready),
    .valid    (valid),
    .out_ack  (out_ack),
    .product  (product),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_res  (alu_res),
    .alu_zero (alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU model: only the two codes the sequencer uses matter here.
  always_comb begin
    alu_res = 32'd0;
    if (alu_op == OP_ADD)      alu_res = alu_a + alu_b;
    else if (alu_op == OP_SRL) alu_res = alu_b >> 1;
    alu_zero = (alu_res == 32'd0);
  end

  // Global time guard so the bench can never hang.
  initial begin
    #3000000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference latency: 2*(k+1), k = highest set bit of b (0 when b==0).
  function automatic int ref_latency(input logic [31:0] b);
    int k = 0;
    for (int i = 0; i < 32; i++) if (b[i]) k = i;
    return 2 * (k + 1);
  endfunction

  function automatic logic [31:0] ref_product(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] full;
    full = {32'd0, a} * {32'd0, b};
    return full[31:0];
  endfunction

  // Issue one request and follow it until valid, checking the alternating ALU
  // op sequence, latency and product. Leaves the DUT in DONE, 1 time unit after an edge.
  task automatic run_req(input logic [31:0] a, input logic [31:0] b, input string tag);
    int cyc;
    int lat;
    check({tag, "_ready_before"}, 64'(ready), 64'd1);
    @(negedge clk);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = ref_latency(b);
    cyc = 0;
    while (valid !== 1'b1 && cyc < 80) begin
      check({tag, "_alu_op"}, 64'(alu_op), (cyc % 2 == 0) ? 64'(OP_ADD) : 64'(OP_SRL));
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(lat));
    check({tag, "_product"}, 64'(product), 64'(ref_product(a, b)));
    $display("req %s a=%08h b=%08h product=%08h cycles=%0d", tag, a, b, product, cyc);
  endtask

  // Acknowledge the held product; optionally raise start in the same cycle.
  task automatic ack_req(input logic with_start, input string tag);
    @(negedge clk);
    out_ack = 1'b1;
    start   = with_start;
    a_in    = $urandom;
    b_in    = $urandom;
    @(posedge clk);
    #1;
    out_ack = 1'b0;
    start   = 1'b0;
    check({tag, "_ack_ready"}, 64'(ready), 64'd1);
    check({tag, "_ack_valid"}, 64'(valid), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, held;
    rst = 1'b1; start = 1'b0; a_in = 32'd0; b_in = 32'd0; out_ack = 1'b0;

    // 1. Reset values.
    #12;
    check("rst_ready",   64'(ready),   64'd1);
    check("rst_valid",   64'(valid),   64'd0);
    check("rst_product", 64'(product), 64'd0);
    check("rst_alu_op",  64'(alu_op),  64'(OP_ADD));
    check("rst_alu_a",   64'(alu_a),   64'd0);
    check("rst_alu_b",   64'(alu_b),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_ready", 64'(ready), 64'd1);

    // 2..4. Directed operand patterns.
    run_req(32'd7, 32'd6, "7x6");
    ack_req(1'b0, "7x6");
    run_req(32'h12345678, 32'd0, "b_zero");
    ack_req(1'b0, "b_zero");
    run_req(32'hFFFFFFFF, 32'hFFFFFFFF, "max_max");
    ack_req(1'b0, "max_max");

    // 5. Hold DONE for 5 cycles while pulsing start; nothing may change.
    run_req(32'd1000, 32'd77, "hold");
    held = product;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = (i % 2 == 0);
      a_in  = $urandom;
      b_in  = $urandom;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("hold_valid",   64'(valid),   64'd1);
      check("hold_product", 64'(product), 64'(held));
      check("hold_ready",   64'(ready),   64'd0);
    end
    // Start together with ack: only the ack acts, start is not queued.
    ack_req(1'b1, "hold");
    @(posedge clk);
    #1;
    check("no_queued_start_ready", 64'(ready), 64'd1);
    check("no_queued_start_valid", 64'(valid), 64'd0);
    run_req(32'd9, 32'd11, "after_hold");
    ack_req(1'b0, "after_hold");

    // 6. Reset during ADD aborts at once; a repeat request completes.
    @(negedge clk);
    start = 1'b1; a_in = 32'd3; b_in = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("abort_in_add_op", 64'(alu_op), 64'(OP_ADD));
    rst = 1'b1;
    #1;
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_valid", 64'(valid), 64'd0);
    $display("req abort a=00000003 b=00000005 ready=%0b valid=%0b", ready, valid);
    @(negedge clk);
    rst = 1'b0;
    run_req(32'd3, 32'd5, "3x5");
    ack_req(1'b0, "3x5");

    // Random operands with varied multiplier widths (and hence latencies).
    for (int n = 0; n < 20; n++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      run_req(ra, rb, "rand");
      ack_req(1'b0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
